delay_chain_sensor: RTL and testbench

DELAY_CHAIN_SENSOR -- requirements
Module: delay_chain_sensor

---
 rtl/delay_sensor_pkg.sv | 14 +
 rtl/delay_chain_sensor_if.sv | 19 +
 rtl/delay_tap_chain.sv | 18 +
 rtl/delay_chain_sensor.sv | 103 ++++++++++
 tb/tb_delay_chain_sensor.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/delay_sensor_pkg.sv
// Shared types and defaults for the delay-chain timing sensor.
package delay_sensor_pkg;
  localparam int CHAIN_LEN_DEF  = 20;
  localparam int SETTLE_CYC_DEF = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    LAUNCH  = 3'd2,
    CAPTURE = 3'd3,
    ENCODE  = 3'd4,
    VALID   = 3'd5
  } sensorState_t;
endpackage

// File: rtl/delay_chain_sensor_if.sv
// Request/result bundle between the delay-chain sensor and its consumer.
interface delay_chain_sensor_if
  import delay_sensor_pkg::*;
#(
  parameter int CNT_W = $clog2(CHAIN_LEN_DEF + 1)
);
  logic             start;
  logic             contMode;
  logic             measReady;
  logic             measValid;
  logic [CNT_W-1:0] measCount;
  logic             measSat;
  logic             busy;

  modport master (input start, contMode, measReady,
                  output measValid, measCount, measSat, busy);
  modport slave  (output start, contMode, measReady,
                  input measValid, measCount, measSat, busy);
endinterface

// File: rtl/delay_tap_chain.sv
// Chain of inverting stages; every stage output is exposed as a tap.
module delay_tap_chain #(
  parameter int CHAIN_LEN = 20
) (
  input  logic                 chainIn,
  output logic [CHAIN_LEN-1:0] taps
);
  for (genvar i = 0; i < CHAIN_LEN; i++) begin : gStage
    // Each stage is a distinct kept net so the inverters survive optimisation.
    (* keep = "true", dont_touch = "true" *) logic stg;
    if (i == 0) begin : gFirst
      assign stg = ~chainIn;
    end else begin : gRest
      assign stg = ~gStage[i-1].stg;
    end
    assign taps[i] = stg;
  end
endmodule

// File: rtl/delay_chain_sensor.sv
// Launches an edge into an inverter chain, captures one clock later, reports stages crossed.
// Optional min/max statistics enabled with DELAY_CHAIN_SENSOR_MINMAX_EN.
module delay_chain_sensor
  import delay_sensor_pkg::*;
#(
  parameter int CHAIN_LEN  = CHAIN_LEN_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rstN,
  delay_chain_sensor_if.master     bus
`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
  ,
  input  logic                     statClear,
  output logic [CNT_W-1:0]         minCount,
  output logic [CNT_W-1:0]         maxCount
`endif
);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  sensorState_t         state, nextState;
  logic                 launch;
  logic [SW-1:0]        settleCnt;
  logic [CHAIN_LEN-1:0] taps, nVec, capVec;
  logic [CNT_W-1:0]     popCnt, measCount;
  logic                 measSat;
  logic                 handshake;

  delay_tap_chain #(.CHAIN_LEN(CHAIN_LEN)) uChain (
    .chainIn (launch),
    .taps    (taps)
  );

  // Undo the alternating inversion so every settled tap reads as the launch level.
  always_comb begin
    nVec = '0;
    for (int i = 0; i < CHAIN_LEN; i++) nVec[i] = taps[i] ^ (i % 2 == 0);
  end

  // Population count tolerates bubbles in the captured thermometer code.
  always_comb begin
    popCnt = '0;
    for (int i = 0; i < CHAIN_LEN; i++) popCnt = popCnt + CNT_W'(capVec[i]);
  end

  assign handshake = (state == VALID) && bus.measReady;

  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.start || bus.contMode) nextState = SETTLE;
      SETTLE:  if (settleCnt == SW'(SETTLE_CYC - 1)) nextState = LAUNCH;
      LAUNCH:  nextState = CAPTURE;
      CAPTURE: nextState = ENCODE;
      ENCODE:  nextState = VALID;
      VALID:   if (bus.measReady) nextState = bus.contMode ? SETTLE : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      launch    <= 1'b0;
      settleCnt <= '0;
      capVec    <= '0;
      measCount <= '0;
      measSat   <= 1'b0;
    end else begin
      // Launch level stays high until the result is consumed, low again for the next settle.
      launch    <= (nextState == LAUNCH) || (nextState == CAPTURE) ||
                   (nextState == ENCODE) || (nextState == VALID);
      settleCnt <= (state == SETTLE && nextState == SETTLE) ? settleCnt + 1'b1 : '0;
      if (state == LAUNCH) capVec <= nVec;
      if (state == ENCODE) begin
        measCount <= popCnt;
        measSat   <= (popCnt == CNT_W'(CHAIN_LEN));
      end
    end
  end

  assign bus.measValid = (state == VALID);
  assign bus.measCount = measCount;
  assign bus.measSat   = measSat;
  assign bus.busy      = (state != IDLE);

`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
  always_ff @(posedge clk) begin
    if (!rstN || statClear) begin
      minCount <= CNT_W'(CHAIN_LEN);
      maxCount <= '0;
    end else if (handshake) begin
      if (measCount < minCount) minCount <= measCount;
      if (measCount > maxCount) maxCount <= measCount;
    end
  end
`endif
endmodule

// File: tb/tb_delay_chain_sensor.sv
// Directed bench for delay_chain_sensor (CHAIN_LEN 20, SETTLE_CYC 4); taps are forced.
// Define DELAY_CHAIN_SENSOR_MINMAX_EN to also exercise the min/max statistics.
module tb_delay_chain_sensor;
  import delay_sensor_pkg::*;

  localparam int CW = 5;
  localparam logic [19:0] EVEN = 20'h55555;

  logic clk = 1'b0;
  logic rstN;
  int   checks = 0;
  int   fails  = 0;
  logic [19:0] tapVal;

  delay_chain_sensor_if #(.CNT_W(CW)) bus ();

`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
  logic          statClear;
  logic [CW-1:0] minCount, maxCount;
`endif

  delay_chain_sensor dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
    ,
    .statClear (statClear),
    .minCount  (minCount),
    .maxCount  (maxCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic setN(input logic [19:0] n);
    tapVal = n ^ EVEN;
    force dut.uChain.taps = tapVal;
  endtask

  // Single-shot measurement: valid must appear on the 8th edge counting the start-sampling edge.
  task automatic measure(input string tag, input logic [19:0] n, input int expCnt, input int expSat);
    setN(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({tag, "_busy"}, int'(bus.busy), 1);
    repeat (6) tick();
    chk({tag, "_early"}, int'(bus.measValid), 0);
    tick();
    chk({tag, "_valid"}, int'(bus.measValid), 1);
    chk({tag, "_count"}, int'(bus.measCount), expCnt);
    chk({tag, "_sat"}, int'(bus.measSat), expSat);
    bus.measReady = 1'b1;
    tick();
    bus.measReady = 1'b0;
    chk({tag, "_done"}, int'(bus.busy), 0);
  endtask

  initial begin
    rstN = 1'b0;
    bus.start = 1'b0;
    bus.contMode = 1'b0;
    bus.measReady = 1'b0;
`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
    statClear = 1'b0;
`endif
    setN(20'h0007F);
    tick();
    tick();
    rstN = 1'b1;
    chk("rst_valid", int'(bus.measValid), 0);
    chk("rst_count", int'(bus.measCount), 0);
    chk("rst_sat", int'(bus.measSat), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_state", int'(dut.state), int'(IDLE));
`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
    chk("rst_min", int'(minCount), 20);
    chk("rst_max", int'(maxCount), 0);
`endif

    measure("n7f", 20'h0007F, 7, 0);
    measure("full", 20'hFFFFF, 20, 1);
    measure("bubble", 20'h0005B, 5, 0);

    // Continuous mode with a stalled consumer.
    setN(20'h0007F);
    bus.contMode = 1'b1;
    repeat (8) tick();
    chk("cont_valid", int'(bus.measValid), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", int'(bus.measValid), 1);
      chk("stall_count", int'(bus.measCount), 7);
    end
    bus.measReady = 1'b1;
    tick();
    bus.measReady = 1'b0;
    chk("cont_resettle", int'(dut.state), int'(SETTLE));
    chk("cont_valid_lo", int'(bus.measValid), 0);
    bus.contMode = 1'b0;
    setN(20'h00007);
    repeat (6) tick();
    chk("cont2_early", int'(bus.measValid), 0);
    tick();
    chk("cont2_valid", int'(bus.measValid), 1);
    chk("cont2_count", int'(bus.measCount), 3);
    bus.measReady = 1'b1;
    tick();
    bus.measReady = 1'b0;
    chk("cont2_idle", int'(dut.state), int'(IDLE));

    // Reset during CAPTURE aborts and clears everything.
    setN(20'h00FFF);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    chk("abort_in_capture", int'(dut.state), int'(CAPTURE));
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    chk("abort_state", int'(dut.state), int'(IDLE));
    chk("abort_valid", int'(bus.measValid), 0);
    chk("abort_count", int'(bus.measCount), 0);
    chk("abort_sat", int'(bus.measSat), 0);
    chk("abort_busy", int'(bus.busy), 0);
    tick();
    tick();
    measure("post_abort", 20'h0007F, 7, 0);

`ifdef DELAY_CHAIN_SENSOR_MINMAX_EN
    statClear = 1'b1;
    tick();
    statClear = 1'b0;
    measure("mm7", 20'h0007F, 7, 0);
    measure("mm3", 20'h00007, 3, 0);
    measure("mm12", 20'h00FFF, 12, 0);
    chk("mm_min", int'(minCount), 3);
    chk("mm_max", int'(maxCount), 12);
    statClear = 1'b1;
    tick();
    statClear = 1'b0;
    chk("clr_min", int'(minCount), 20);
    chk("clr_max", int'(maxCount), 0);
    // statClear wins over a same-cycle handshake.
    setN(20'h0001F);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    chk("prio_valid", int'(bus.measValid), 1);
    bus.measReady = 1'b1;
    statClear = 1'b1;
    tick();
    bus.measReady = 1'b0;
    statClear = 1'b0;
    chk("prio_min", int'(minCount), 20);
    chk("prio_max", int'(maxCount), 0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
